barret_347_rr_sched: RTL



---
 rtl/barret_347_pkg.sv | 26 ++
 rtl/barret_347_rr_arb.sv | 50 +++++
 rtl/barret_for_347.sv | 23 ++
 rtl/barret_347_rr_sched.sv | 103 ++++++++++
 4 files changed

// File: rtl/barret_347_pkg.sv
// Shared constants and pipeline stage records for the mod-347 reduction scheduler.
package barret_347_pkg;

  localparam int Q           = 347;
  localparam int DIN_W       = 17;
  localparam int DOUT_W      = 9;
  localparam int MAX_OPERAND = 120408;
  localparam int MAX_ID_W    = 3;

  // Stage 1 record: raw operand waiting for reduction.
  typedef struct packed {
    logic                valid;
    logic [DIN_W-1:0]    data;
    logic [MAX_ID_W-1:0] id;
    logic                err;
  } s1_rec_t;

  // Stage 2 record: reduced residue presented on the outputs.
  typedef struct packed {
    logic                valid;
    logic [DOUT_W-1:0]   data;
    logic [MAX_ID_W-1:0] id;
    logic                err;
  } s2_rec_t;

endpackage

// File: rtl/barret_347_rr_arb.sv
// Round-robin grant generation with a rotating priority pointer.
module barret_347_rr_arb
  import barret_347_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               adv,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    gnt_id,
  output logic               any_grant
);

  logic [ID_W-1:0] ptr_reg;
  logic [ID_W-1:0] ptr_next;
  logic [ID_W:0]   idx_sum;
  logic [ID_W:0]   inc;

  always_comb begin
    grant     = '0;
    gnt_id    = '0;
    any_grant = 1'b0;
    idx_sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_sum = {1'b0, ptr_reg} + (ID_W+1)'(k);
      if (idx_sum >= (ID_W+1)'(NUM_REQ))
        idx_sum = idx_sum - (ID_W+1)'(NUM_REQ);
      if (!any_grant && req_valid[idx_sum[ID_W-1:0]]) begin
        grant[idx_sum[ID_W-1:0]] = 1'b1;
        gnt_id                   = idx_sum[ID_W-1:0];
        any_grant                = 1'b1;
      end
    end
  end

  // Priority moves just past the requester that was served.
  assign inc      = {1'b0, gnt_id} + (ID_W+1)'(1);
  assign ptr_next = (inc >= (ID_W+1)'(NUM_REQ)) ? '0 : inc[ID_W-1:0];

  always_ff @(posedge clk) begin
    if (rst)
      ptr_reg <= '0;
    else if (adv && any_grant)
      ptr_reg <= ptr_next;
  end

endmodule

// File: rtl/barret_for_347.sv
// Combinational Barrett reduction of a 17-bit operand modulo 347.
module barret_for_347
  import barret_347_pkg::*;
(
  input  logic [DIN_W-1:0]  din,
  output logic [DOUT_W-1:0] dout
);

  // m = floor(2^18 / 347); the quotient estimate is at most one short over the
  // full 17-bit input range, so a single conditional subtract suffices.
  localparam int K = 18;
  localparam int M = 755;

  logic [26:0] prod;
  logic [8:0]  q_est;
  logic [9:0]  r0;

  assign prod  = {10'b0, din} * 27'(M);
  assign q_est = 9'(prod >> K);
  assign r0    = 10'({1'b0, din} - 18'(q_est) * 18'(Q));
  assign dout  = 9'((r0 >= 10'(Q)) ? (r0 - 10'(Q)) : r0);

endmodule

// File: rtl/barret_347_rr_sched.sv
// Round-robin scheduler feeding one mod-347 reducer through two registered stages.
// Optional range check on operands enabled by defining BARRET_347_RANGE_CHK_EN.
module barret_347_rr_sched
  import barret_347_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*DIN_W-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     out_valid,
  output logic [DOUT_W-1:0]        out_data,
  output logic [ID_W-1:0]          out_id,
  output logic                     out_err,
  input  logic                     out_ready
);

  s1_rec_t s1_reg, s1_next;
  s2_rec_t s2_reg, s2_next;

  logic                 adv;
  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      gnt_id;
  logic                 any_grant;
  logic [DIN_W-1:0]     operand [NUM_REQ];
  logic [DOUT_W-1:0]    residue;
  logic                 unused_bits;

  assign adv = !s2_reg.valid || out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign operand[gi]   = req_data[DIN_W*gi +: DIN_W];
      assign req_ready[gi] = adv && grant[gi] && !rst;
    end
  endgenerate

  barret_347_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .adv       (adv),
    .grant     (grant),
    .gnt_id    (gnt_id),
    .any_grant (any_grant)
  );

  barret_for_347 u_red (
    .din  (s1_reg.data),
    .dout (residue)
  );

  always_comb begin
    s1_next       = '0;
    s1_next.valid = any_grant;
    s1_next.data  = operand[gnt_id];
    s1_next.id    = MAX_ID_W'(gnt_id);
`ifdef BARRET_347_RANGE_CHK_EN
    s1_next.err   = (operand[gnt_id] > DIN_W'(MAX_OPERAND));
`else
    s1_next.err   = 1'b0;
`endif
  end

  always_comb begin
    s2_next       = '0;
    s2_next.valid = s1_reg.valid;
    s2_next.id    = s1_reg.id;
`ifdef BARRET_347_RANGE_CHK_EN
    // Out-of-range operands still occupy a slot but return a zero residue.
    s2_next.err   = s1_reg.err;
    s2_next.data  = s1_reg.err ? '0 : residue;
`else
    s2_next.err   = 1'b0;
    s2_next.data  = residue;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg <= '0;
      s2_reg <= '0;
    end else if (adv) begin
      s1_reg <= s1_next;
      s2_reg <= s2_next;
    end
  end

  assign out_valid = s2_reg.valid;
  assign out_data  = s2_reg.data;
  assign out_id    = s2_reg.id[ID_W-1:0];
  assign out_err   = s2_reg.err;

  // Id bits above ID_W and the stage-1 error flag may be unread in some builds.
  assign unused_bits = ^{s1_reg.err, s2_reg.id};

endmodule
